// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared types and constants for the MMIO interconnect
// Contents: FSM state encoding, default error read data, canonical address
// windows (instruction memory, data memory, timer, UART) for building
// SLAVE_BASE / SLAVE_MASK.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mmio_state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  localparam logic [31:0] IMEM_BASE  = 32'h0000_0000;
  localparam logic [31:0] IMEM_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] DMEM_BASE  = 32'h1000_0000;
  localparam logic [31:0] DMEM_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] TIMER_BASE = 32'h2000_0000;
  localparam logic [31:0] TIMER_MASK = 32'hFFFF_FF00;
  localparam logic [31:0] UART_BASE  = 32'h3000_0000;
  localparam logic [31:0] UART_MASK  = 32'hFFFF_FF00;

endpackage

// File: rtl/mmio_addr_decode.sv
// rtl/mmio_addr_decode.sv - combinational priority address decoder
// Ports:
//   addr   in  ADDR_W      address to decode
//   hit    out 1           some window matched
//   sel    out NUM_SLAVES  one-hot select of the lowest-index matching window
//   offset out ADDR_W      addr minus the matching window base
module mmio_addr_decode #(
  parameter int                           NUM_SLAVES = 4,
  parameter int                           ADDR_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic                  hit,
  output logic [NUM_SLAVES-1:0] sel,
  output logic [ADDR_W-1:0]     offset
);

  // Scan from the highest index down so the lowest matching index overwrites
  // the others and wins on overlapping windows.
  always_comb begin
    hit    = 1'b0;
    sel    = '0;
    offset = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
        hit    = 1'b1;
        sel    = NUM_SLAVES'(1) << i;
        offset = addr - SLAVE_BASE[i*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/mmio_interconnect.sv
// rtl/mmio_interconnect.sv - registered memory-mapped interconnect, one master to NUM_SLAVES targets
// Optional feature macro: BUS_TIMEOUT_EN (slave wait timeout with bus error).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   m_addr/m_wdata/m_be/m_we/m_re master request (sampled in IDLE only)
//   m_rdata/m_ready/m_err/m_busy  master response, all registered
//   s_sel/s_addr/s_wdata/s_be     slave request, shared except one-hot s_sel
//   s_we/s_re                     slave strobes, qualified by s_sel
//   s_rdata/s_ready               flattened per-slave read data and completion
module mmio_interconnect
  import mmio_pkg::*;
#(
  parameter int                           NUM_SLAVES     = 4,
  parameter int                           ADDR_W         = 32,
  parameter int                           DATA_W         = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE     = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK     = '0,
  parameter int                           TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0]            ERR_DATA       = DATA_W'(ERR_DATA_DEFAULT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  input  logic [DATA_W/8-1:0]          m_be,
  input  logic                         m_we,
  input  logic                         m_re,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_ready,
  output logic                         m_err,
  output logic                         m_busy,
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_be,
  output logic                         s_we,
  output logic                         s_re,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_ready
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || (DATA_W % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("mmio_interconnect: illegal parameter combination");
  end

  mmio_state_t state;

  logic                  dec_hit;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic [ADDR_W-1:0]     dec_offset;

  mmio_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .addr   (m_addr),
    .hit    (dec_hit),
    .sel    (dec_sel),
    .offset (dec_offset)
  );

  // The registered one-hot s_sel doubles as the response mux select, so
  // ready/data from unselected slaves never reach the FSM.
  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (s_sel[i]) sel_rdata = sel_rdata | s_rdata[i*DATA_W +: DATA_W];
    end
  end

  assign sel_ready = |(s_ready & s_sel);

`ifdef BUS_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] to_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      s_sel   <= '0;
      s_we    <= 1'b0;
      s_re    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_be    <= '0;
      m_rdata <= '0;
      m_ready <= 1'b0;
      m_err   <= 1'b0;
      m_busy  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      to_cnt  <= '0;
`endif
    end else begin
      m_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (m_we || m_re) begin
            m_busy <= 1'b1;
            if (dec_hit) begin
              state   <= ACCESS;
              s_sel   <= dec_sel;
              s_addr  <= dec_offset;
              s_wdata <= m_wdata;
              s_be    <= m_be;
              // A combined write+read request performs only the write.
              s_we    <= m_we;
              s_re    <= m_re & ~m_we;
`ifdef BUS_TIMEOUT_EN
              to_cnt  <= '0;
`endif
            end else begin
              state   <= RESP;
              m_err   <= 1'b1;
              m_rdata <= ERR_DATA;
            end
          end
        end
        ACCESS: begin
          // s_ready is tested first so a completion in the final wait
          // cycle beats the timeout.
          if (sel_ready) begin
            state   <= RESP;
            m_err   <= 1'b0;
            m_rdata <= s_re ? sel_rdata : '0;
            s_sel   <= '0;
            s_we    <= 1'b0;
            s_re    <= 1'b0;
          end
`ifdef BUS_TIMEOUT_EN
          else if (to_cnt == CNT_LAST) begin
            state   <= RESP;
            m_err   <= 1'b1;
            m_rdata <= ERR_DATA;
            s_sel   <= '0;
            s_we    <= 1'b0;
            s_re    <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          state   <= IDLE;
          m_ready <= 1'b1;
          m_busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_interconnect.sv
// tb/tb_mmio_interconnect.sv - self-checking bench for mmio_interconnect
module tb_mmio_interconnect;
  import mmio_pkg::*;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 8;

  // slave0: 16-byte window at 0x02000000; slave1: 0x02xxxxxx; slave2:
  // 0x0200xxxx (overlaps both); slave3: UART window.
  localparam logic [NS*AW-1:0] BASE = {UART_BASE, 32'h0200_0000, 32'h0200_0000, 32'h0200_0000};
  localparam logic [NS*AW-1:0] MASK = {UART_MASK, 32'hFFFF_0000, 32'hFF00_0000, 32'hFFFF_FFF0};

  logic [31:0] base_a [NS] = '{32'h0200_0000, 32'h0200_0000, 32'h0200_0000, UART_BASE};
  logic [31:0] mask_a [NS] = '{32'hFFFF_FFF0, 32'hFF00_0000, 32'hFFFF_0000, UART_MASK};
  logic [31:0] data_a [NS] = '{32'hA0A0_0000, 32'h1234_5678, 32'hC2C2_C2C2, 32'hD3D3_D3D3};

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [AW-1:0]      m_addr = '0;
  logic [DW-1:0]      m_wdata = '0;
  logic [BW-1:0]      m_be = '0;
  logic               m_we = 1'b0;
  logic               m_re = 1'b0;
  logic [DW-1:0]      m_rdata;
  logic               m_ready;
  logic               m_err;
  logic               m_busy;
  logic [NS-1:0]      s_sel;
  logic [AW-1:0]      s_addr;
  logic [DW-1:0]      s_wdata;
  logic [BW-1:0]      s_be;
  logic               s_we;
  logic               s_re;
  logic [NS*DW-1:0]   s_rdata;
  logic [NS-1:0]      s_ready = '1;

  assign s_rdata = {data_a[3], data_a[2], data_a[1], data_a[0]};

  mmio_interconnect #(
    .NUM_SLAVES     (NS),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .SLAVE_BASE     (BASE),
    .SLAVE_MASK     (MASK),
    .TIMEOUT_CYCLES (TO),
    .ERR_DATA       (32'hDEAD_BEEF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_be    (m_be),
    .m_we    (m_we),
    .m_re    (m_re),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .m_err   (m_err),
    .m_busy  (m_busy),
    .s_sel   (s_sel),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_be    (s_be),
    .s_we    (s_we),
    .s_re    (s_re),
    .s_rdata (s_rdata),
    .s_ready (s_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Slave models: a selected slave raises s_ready after wait_cfg cycles;
  // unselected slaves hold s_ready high, which the interconnect must ignore.
  int wait_cfg = 0;
  int acc_cnt [NS];

  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (s_sel[i]) begin
        s_ready[i] = (acc_cnt[i] >= wait_cfg);
        acc_cnt[i]++;
      end else begin
        acc_cnt[i] = 0;
        s_ready[i] = 1'b1;
      end
    end
  end

  // Transaction model: expectations derived from the decode windows and the
  // latency rules (2 cycles to respond after the access phase ends).
  bit          mon_en = 1'b0;
  bit          active = 1'b0;
  int          cyc = 0;
  bit          exp_hit;
  logic [3:0]  exp_sel;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_be;
  bit          exp_we, exp_re, exp_err;
  int          exp_acc, exp_lat;
  logic [31:0] model_rdata = '0;

  int          obs_ready_cyc, obs_stable;
  logic [3:0]  obs_sel;
  logic [31:0] obs_addr, obs_rdata;
  bit          obs_err, obs_we, obs_re;

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (active) begin
        bit in_acc;
        cyc++;
        in_acc = exp_hit && (cyc <= exp_acc);
        chk("busy", 64'(m_busy), 64'(cyc < exp_lat));
        chk("ready", 64'(m_ready), 64'(cyc == exp_lat));
        chk("s_sel", 64'(s_sel), in_acc ? 64'(exp_sel) : 64'd0);
        chk("s_we", 64'(s_we), 64'(in_acc && exp_we));
        chk("s_re", 64'(s_re), 64'(in_acc && exp_re));
        if (in_acc) begin
          chk("s_addr", 64'(s_addr), 64'(exp_addr));
          chk("s_wdata", 64'(s_wdata), 64'(exp_wdata));
          chk("s_be", 64'(s_be), 64'(exp_be));
          obs_stable++;
        end
        if (s_sel != 4'd0 && obs_sel == 4'd0) begin
          obs_sel  = s_sel;
          obs_addr = s_addr;
          obs_we   = s_we;
          obs_re   = s_re;
        end
        if (m_ready) begin
          obs_ready_cyc = cyc;
          obs_err       = m_err;
          obs_rdata     = m_rdata;
        end
        if (cyc == exp_lat) begin
          chk("m_err", 64'(m_err), 64'(exp_err));
          chk("m_rdata", 64'(m_rdata), 64'(exp_rdata));
          model_rdata = exp_rdata;
          active = 1'b0;
        end
      end else begin
        chk("idle_ready", 64'(m_ready), 64'd0);
        chk("idle_busy", 64'(m_busy), 64'd0);
        chk("idle_sel", 64'(s_sel), 64'd0);
        chk("idle_rdata_hold", 64'(m_rdata), 64'(model_rdata));
      end
    end
  end

  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                         input logic we, input logic re, input int wait_i);
    int idx = -1;
    for (int i = 0; i < NS; i++)
      if (idx < 0 && (addr & mask_a[i]) == base_a[i]) idx = i;
    exp_hit   = (idx >= 0);
    exp_wdata = wdata;
    exp_be    = be;
    exp_we    = we;
    exp_re    = re && !we;
    if (exp_hit) begin
      exp_sel  = 4'(1 << idx);
      exp_addr = addr - base_a[idx];
      exp_acc  = wait_i + 1;
      exp_err  = 1'b0;
`ifdef BUS_TIMEOUT_EN
      if (exp_acc > TO) begin
        exp_acc = TO;
        exp_err = 1'b1;
      end
`endif
      exp_rdata = exp_err ? 32'hDEAD_BEEF : (we ? 32'd0 : data_a[idx]);
      exp_lat   = exp_acc + 2;
    end else begin
      exp_sel   = 4'd0;
      exp_addr  = 32'd0;
      exp_acc   = 0;
      exp_err   = 1'b1;
      exp_rdata = 32'hDEAD_BEEF;
      exp_lat   = 2;
    end
    obs_ready_cyc = -1;
    obs_stable    = 0;
    obs_sel       = 4'd0;
    obs_addr      = 32'd0;
    obs_rdata     = 32'd0;
    obs_err       = 1'b0;
    obs_we        = 1'b0;
    obs_re        = 1'b0;
    wait_cfg      = wait_i;
    @(negedge clk);
    m_addr  = addr;
    m_wdata = wdata;
    m_be    = be;
    m_we    = we;
    m_re    = re;
    cyc     = 0;
    active  = 1'b1;
    // Master inputs are junk while busy; they must not disturb the capture.
    for (int k = 1; k <= exp_lat; k++) begin
      @(negedge clk);
      if (k < exp_lat) begin
        m_addr  = $urandom;
        m_wdata = $urandom;
        m_be    = 4'($urandom);
        m_we    = 1'($urandom);
        m_re    = 1'($urandom);
      end else begin
        m_we = 1'b0;
        m_re = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NS; i++) acc_cnt[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", 64'(s_sel), 64'd0);
    chk("rst_we_re", 64'({s_we, s_re}), 64'd0);
    chk("rst_addr", 64'(s_addr), 64'd0);
    chk("rst_wdata_be", 64'({s_wdata, s_be}), 64'd0);
    chk("rst_rdata", 64'(m_rdata), 64'd0);
    chk("rst_flags", 64'({m_ready, m_err, m_busy}), 64'd0);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Zero-wait read of slave1.
    run_txn(32'h0200_0010, 32'd0, 4'hF, 1'b0, 1'b1, 0);
    chk("t1_lat", 64'(obs_ready_cyc), 64'd3);
    chk("t1_sel", 64'(obs_sel), 64'h2);
    chk("t1_saddr", 64'(obs_addr), 64'h10);
    chk("t1_rdata", 64'(obs_rdata), 64'h1234_5678);
    chk("t1_err", 64'(obs_err), 64'd0);

    // Write to slave0 with five wait states.
    run_txn(32'h0200_0004, 32'hA5A5_A5A5, 4'b0011, 1'b1, 1'b0, 5);
    chk("t2_lat", 64'(obs_ready_cyc), 64'd8);
    chk("t2_stable", 64'(obs_stable), 64'd6);
    chk("t2_sel", 64'(obs_sel), 64'h1);
    chk("t2_err_rdata", 64'({obs_err, obs_rdata}), 64'd0);

    // Unmapped read.
    run_txn(32'hF000_0000, 32'd0, 4'hF, 1'b0, 1'b1, 0);
    chk("t3_lat", 64'(obs_ready_cyc), 64'd2);
    chk("t3_sel", 64'(obs_sel), 64'd0);
    chk("t3_err", 64'(obs_err), 64'd1);
    chk("t3_rdata", 64'(obs_rdata), 64'hDEAD_BEEF);

    // Overlapping windows with simultaneous write and read strobes.
    run_txn(32'h0200_0000, 32'h0BAD_F00D, 4'hF, 1'b1, 1'b1, 1);
    chk("t4_sel", 64'(obs_sel), 64'h1);
    chk("t4_we_re", 64'({obs_we, obs_re}), 64'b10);
    chk("t4_lat", 64'(obs_ready_cyc), 64'd4);

    // UART window read with two wait states.
    run_txn(UART_BASE + 32'h8, 32'd0, 4'hF, 1'b0, 1'b1, 2);
    chk("t5_sel", 64'(obs_sel), 64'h8);
    chk("t5_saddr", 64'(obs_addr), 64'h8);
    chk("t5_rdata", 64'(obs_rdata), 64'hD3D3_D3D3);
    chk("t5_lat", 64'(obs_ready_cyc), 64'd5);

`ifdef BUS_TIMEOUT_EN
    run_txn(32'h0200_0010, 32'd0, 4'hF, 1'b0, 1'b1, 1000);
    chk("to_err", 64'(obs_err), 64'd1);
    chk("to_rdata", 64'(obs_rdata), 64'hDEAD_BEEF);
    chk("to_lat", 64'(obs_ready_cyc), 64'd10);
    run_txn(32'h0200_0010, 32'd0, 4'hF, 1'b0, 1'b1, 7);
    chk("to_edge_err", 64'(obs_err), 64'd0);
    chk("to_edge_rdata", 64'(obs_rdata), 64'h1234_5678);
    chk("to_edge_lat", 64'(obs_ready_cyc), 64'd10);
`endif

    // Reset in the middle of a wait state.
    mon_en   = 1'b0;
    wait_cfg = 20;
    @(negedge clk);
    m_addr  = 32'h0200_0008;
    m_wdata = 32'h5555_AAAA;
    m_be    = 4'hF;
    m_we    = 1'b1;
    @(negedge clk);
    m_we = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_sel", 64'(s_sel), 64'h1);
    chk("mid_busy", 64'(m_busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_sel", 64'(s_sel), 64'd0);
    chk("mid_rst_strobes", 64'({s_we, s_re}), 64'd0);
    chk("mid_rst_bus", 64'({s_addr, s_wdata, s_be}), 64'd0);
    chk("mid_rst_master", 64'({m_ready, m_err, m_busy}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_ready", 64'({m_ready, m_busy}), 64'd0);
    end
    model_rdata = 32'd0;
    mon_en      = 1'b1;
    run_txn(32'h0200_0010, 32'd0, 4'hF, 1'b0, 1'b1, 0);
    chk("post_rst_rdata", 64'(obs_rdata), 64'h1234_5678);
    chk("post_rst_lat", 64'(obs_ready_cyc), 64'd3);

    repeat (2) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
